// File: rtl/tm_lif_pkg.sv
// Shared constants and helpers for the time-multiplexed LIF array.
// Provides the default threshold and a saturating W+1 -> W reduction.
package tm_lif_pkg;

  localparam int SAT_MAX_W = 32;

  localparam logic [7:0] THR_DEFAULT_8 = 8'h7F;

  // Clamp a (w+1)-bit sum to the largest w-bit value.
  // Operands are carried at SAT_MAX_W+1 bits so one
  // helper serves every state width up to SAT_MAX_W.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W:0] sum,
    input int unsigned        w
  );
    logic [SAT_MAX_W:0] lim;
    lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    if (sum > lim) sat_add = SAT_MAX_W'(lim);
    else           sat_add = SAT_MAX_W'(sum);
  endfunction

endpackage

// File: rtl/tm_lif_core.sv
// Combinational leak/integrate/saturate/compare for one neuron.
// Ports: v, cur, thr in; v_next, spike out; with TM_LIF_REFRAC_EN
// also cnt in and cnt_next out (refractory visit counter).
module tm_lif_core
  import tm_lif_pkg::*;
#(
  parameter int W           = 8,
  parameter int LEAK_SHIFT  = 3,
  parameter int INPUT_SHIFT = 1
`ifdef TM_LIF_REFRAC_EN
  ,
  parameter int REFRAC_CYCLES = 2,
  parameter int RW = $clog2(REFRAC_CYCLES + 1)
`endif
) (
  input  logic [W-1:0]  v,
  input  logic [W-1:0]  cur,
  input  logic [W-1:0]  thr,
`ifdef TM_LIF_REFRAC_EN
  input  logic [RW-1:0] cnt,
  output logic [RW-1:0] cnt_next,
`endif
  output logic [W-1:0]  v_next,
  output logic          spike
);

  logic [W:0]   sum;
  logic [W-1:0] sat;
  logic         fire;

  // v - (v >> LEAK_SHIFT) never goes negative, so the
  // extra top bit only ever carries the input overflow.
  always_comb begin
    sum = {1'b0, v}
        - {1'b0, v >> LEAK_SHIFT}
        + {1'b0, cur >> INPUT_SHIFT};
    sat = W'(sat_add((SAT_MAX_W+1)'(sum), W));
  end

  assign fire = (sat >= thr);

`ifdef TM_LIF_REFRAC_EN
  always_comb begin
    v_next   = '0;
    spike    = 1'b0;
    cnt_next = '0;
    if (cnt != '0) begin
      cnt_next = cnt - RW'(1);
    end else if (fire) begin
      spike    = 1'b1;
      cnt_next = RW'(REFRAC_CYCLES);
    end else begin
      v_next = sat;
    end
  end
`else
  always_comb begin
    spike  = fire;
    v_next = fire ? '0 : sat;
  end
`endif

endmodule

// File: rtl/tm_lif_array.sv
// Time-multiplexed array of LIF neurons sharing one update datapath.
// Ports: clk, rst (async high), en, current, thr_we/thr_addr/thr_data;
// outputs spike, frame_done, mon_idx, mon_state. Optional refractory
// counters are built when TM_LIF_REFRAC_EN is defined.
module tm_lif_array
  import tm_lif_pkg::*;
#(
  parameter int NUM_NEURONS   = 8,
  parameter int W             = 8,
  parameter int LEAK_SHIFT    = 3,
  parameter int INPUT_SHIFT   = 1,
  parameter logic [W-1:0] THR_DEFAULT = W'(THR_DEFAULT_8),
  parameter int REFRAC_CYCLES = 2,
  localparam int PW = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_NEURONS*W-1:0] current,
  input  logic                   thr_we,
  input  logic [PW-1:0]          thr_addr,
  input  logic [W-1:0]           thr_data,
  output logic [NUM_NEURONS-1:0] spike,
  output logic                   frame_done,
  output logic [PW-1:0]          mon_idx,
  output logic [W-1:0]           mon_state
);

  if (NUM_NEURONS < 2) begin : g_bad_n
    $error("NUM_NEURONS must be at least 2");
  end
  if (REFRAC_CYCLES < 1) begin : g_bad_refrac
    $error("REFRAC_CYCLES must be at least 1");
  end

  localparam logic [PW-1:0] LAST = PW'(NUM_NEURONS - 1);

  logic [PW-1:0] ptr;
  logic [W-1:0]  state [NUM_NEURONS];
  logic [W-1:0]  thr   [NUM_NEURONS];

  logic [NUM_NEURONS-1:0][W-1:0] cur_arr;
  logic [W-1:0] v_next;
  logic         fire;
  logic         thr_ok;

  assign cur_arr = current;
  assign thr_ok  = {1'b0, thr_addr} < (PW+1)'(NUM_NEURONS);

`ifdef TM_LIF_REFRAC_EN
  localparam int RW = $clog2(REFRAC_CYCLES + 1);

  logic [RW-1:0] cnt [NUM_NEURONS];
  logic [RW-1:0] cnt_next;

  tm_lif_core #(
    .W            (W),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .INPUT_SHIFT  (INPUT_SHIFT),
    .REFRAC_CYCLES(REFRAC_CYCLES),
    .RW           (RW)
  ) u_core (
    .v       (state[ptr]),
    .cur     (cur_arr[ptr]),
    .thr     (thr[ptr]),
    .cnt     (cnt[ptr]),
    .cnt_next(cnt_next),
    .v_next  (v_next),
    .spike   (fire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
    end else if (en) begin
      cnt[ptr] <= cnt_next;
    end
  end
`else
  tm_lif_core #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .INPUT_SHIFT(INPUT_SHIFT)
  ) u_core (
    .v     (state[ptr]),
    .cur   (cur_arr[ptr]),
    .thr   (thr[ptr]),
    .v_next(v_next),
    .spike (fire)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      spike      <= '0;
      frame_done <= 1'b0;
      mon_idx    <= '0;
      mon_state  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) state[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        state[ptr] <= v_next;
        spike[ptr] <= fire;
        mon_idx    <= ptr;
        mon_state  <= v_next;
        frame_done <= (ptr == LAST);
        ptr        <= (ptr == LAST) ? '0 : ptr + PW'(1);
      end
    end
  end

  // The core reads thr[ptr] before this edge lands, so a
  // write to the neuron being visited takes effect next visit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) thr[i] <= THR_DEFAULT;
    end else if (thr_we && thr_ok) begin
      thr[thr_addr] <= thr_data;
    end
  end

endmodule

// File: doc/tm_lif_array.md
# tm_lif_array

Parametrised, time-multiplexed array of leaky integrate-and-fire neurons. It is the next generation of the 8-neuron TM LIF block and adds configurable neuron count and state width, per-neuron input currents, a real leak term, saturation, and runtime-programmable per-neuron thresholds. A single shared update datapath visits one neuron per enabled cycle in round-robin order. The block sits between the input current encoder and the spike output/monitor logic of the top-level design.

## Interface
Parameters:
- `NUM_NEURONS`, default 8: neurons in the array; must be ≥2.
- `W`, default 8: membrane state, current and threshold width.
- `LEAK_SHIFT`, default 3: leak is `v >> LEAK_SHIFT`.
- `INPUT_SHIFT`, default 1: input contribution is `I >> INPUT_SHIFT`.
- `THR_DEFAULT`, default 8'h7F: per-neuron threshold after reset, sized to `W`.
- `REFRAC_CYCLES`, default 2: refractory visits. Used only with `TM_LIF_REFRAC_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: advance one neuron update this cycle.
- `current` in `NUM_NEURONS*W`: packed per-neuron input; slice i belongs to neuron i.
- `thr_we` in 1: threshold write strobe.
- `thr_addr` in `$clog2(NUM_NEURONS)`: threshold write index.
- `thr_data` in `W`: threshold write value.
- `spike` out `NUM_NEURONS`: bit i holds the result of neuron i's most recent update.
- `frame_done` out 1: one-cycle pulse after the last neuron is updated.
- `mon_idx` out `$clog2(NUM_NEURONS)`: index of the most recently updated neuron.
- `mon_state` out `W`: post-update state of that neuron.

## Operation
- Slot pointer `ptr` counts 0..`NUM_NEURONS`-1 and wraps to 0. It advances only when `en`=1.
- Each enabled cycle, with v = state[ptr] and I = current slice ptr:
  - sum = v − (v >> LEAK_SHIFT) + (I >> INPUT_SHIFT), computed in W+1 bits.
  - sum saturates to 2^W−1.
- If the saturated sum ≥ thr[ptr]: spike[ptr]←1 and state[ptr]←0. Otherwise spike[ptr]←0 and state[ptr]←sum.
- Spike bits of other neurons hold their values.
- `en`=0: ptr, state, spike, mon_* and thresholds (except writes) hold; `frame_done`=0.
- Threshold write: on `thr_we`, thr[thr_addr]←thr_data, independent of `en`. An out-of-range `thr_addr` is ignored.
- Simultaneous write and update of the same neuron: the comparison uses the old threshold, and the new value applies from that neuron's next visit.

## Timing
- Reset values: state all 0, thresholds all `THR_DEFAULT`, ptr 0, spike 0, frame_done 0, mon_idx 0, mon_state 0.
- Reset mid-frame clears everything immediately. The next enabled cycle updates neuron 0.
- Update latency is 1 cycle. `spike[i]`, `mon_idx`=i and `mon_state` reflect the edge at which ptr==i with en=1.
- `frame_done` is high for the cycle after the edge that updated neuron `NUM_NEURONS`-1.
- Each neuron is updated once every `NUM_NEURONS` enabled cycles.
- `current` is sampled only for the slice selected by ptr on the update edge.

## Configuration
- `TM_LIF_REFRAC_EN` defined:
  - Each neuron has a refractory counter, width `$clog2(REFRAC_CYCLES+1)`, reset to 0.
  - On a spike the counter loads `REFRAC_CYCLES`.
  - On a visit with a nonzero counter: state stays 0, spike←0, and the counter decrements.
- `TM_LIF_REFRAC_EN` undefined: no counters; a neuron integrates again on the visit after its spike.

## Structure
- Package `tm_lif_pkg`: `THR_DEFAULT_8` constant and a `sat_add` helper function for saturating W+1→W reduction.
- Sub-module `tm_lif_core`: combinational leak/integrate/saturate/compare for one neuron. Inputs: v, I, thr, and the refractory count when enabled. Outputs: next v, spike, and next count.
- Top level owns ptr, the state, threshold and refractory arrays, and the output registers.

## Test plan
Defaults: N=8, W=8, LEAK 3, INPUT 1, THR 127, en=1 continuously.
- Reset: assert `rst` mid-frame → spike=0, mon_idx=0, mon_state=0, frame_done=0 immediately; the first enabled edge after release updates neuron 0.
- Integration: current[0]=100, all others 0.
  - mon_state for neuron 0 is 50, then 94, then 0; spike[0] is 0, 0, 1 on visits 1, 2, 3 (edges 1, 9, 17).
  - frame_done pulses after edges 8 and 16.
- Saturation: write thr[2]=255 and set current[2]=255.
  - Visits give 127, then 239, then sum 337 saturates to 255 ≥ 255, giving spike[2]=1 and state 0.
- Threshold write: thr_we with addr 3, data 10, and current[3]=40 → first visit 20 ≥ 10, spike[3]=1.
  - A write to neuron 3 on the same edge as its update applies only from the next visit.
- Enable gating: drop `en` for 5 cycles mid-frame → ptr, mon_*, spike and frame_done frozen; the sequence resumes at the next index.
- With `TM_LIF_REFRAC_EN` and REFRAC_CYCLES=2, neuron 3 (thr 10, current[3]=40) follows spike, 0, 0, then spike on visits 1–4.
